dpd_loop_delay_est: RTL and testbench
=====================================

// Module: dpd_loop_delay_est
// PURPOSE
//  Feedback-side companion to the DPD adaptation engine. It measures the transmit->PA->feedback loop
//  delay in clk cycles, so the DELAY constant of the DPD can be programmed instead of hardcoded.
//  Capture: it records a block of the transmitted training signal and the matching PA feedback.
//  Search: it cross-correlates the two over a lag window and reports the lag with the strongest correlation.
//  Sits beside the DPD core; ref_* taps the training signal at the transmit output, fb_* taps sig_pa_*.
// PARAMETERS
//  N        64      reference block length in samples; power of 2, 16..256
//  MAX_LAG  64      number of lags searched, 0..MAX_LAG-1; power of 2, <=256
//  THRESH   28'd4096  minimum peak metric for a valid lock
// PORTS
//  clk        in   1   clock; all inputs sampled and outputs driven on posedge
//  reset_b    in   1   asynchronous, active-low reset
//  start      in   1   level; a rising edge in IDLE launches one measurement
//  ref_i      in   20  s20 transmitted (training) signal, real part
//  ref_q      in   20  s20 transmitted signal, imaginary part
//  fb_i       in   20  s20 PA feedback, real part
//  fb_q       in   20  s20 PA feedback, imaginary part
//  busy       out  1   high from CAPTURE entry until the done cycle, inclusive
//  done       out  1   one-cycle pulse when a measurement completes
//  lock       out  1   level; 1 = last measurement peak >= THRESH
//  delay      out  8   measured lag (fb lags ref by this many cycles); held between measurements
//  peak       out  28  unsigned peak metric of the last measurement
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; buffers need no reset.
//  Start detect: start is registered; a rising edge (start & ~start_d) is acted on only in IDLE.
//    A rising edge while busy is ignored; no queueing.
//  FSM: IDLE -> CAPTURE -> SEARCH -> DECIDE -> IDLE.
//  CAPTURE: lasts N+MAX_LAG cycles, with sample index k=0.. counted from the first CAPTURE cycle.
//    Each cycle fb[k] is written from the top 10 bits ({fb_i[19:10], fb_q[19:10]}).
//    For k<N only, ref[k] is written in the same cycle from the top 10 bits.
//  SEARCH: for L=0..MAX_LAG-1, acc(L) = sum_{n=0..N-1} ref[n]*conj(fb[n+L]).
//    One complex MAC per cycle, in s10 x s10 arithmetic.
//    Products are full 20 bits; accumulators are 27 bits signed, with no saturation at N<=64.
//    The bench is generated with N=64.
//    Each lag takes N+3 cycles: N MACs plus a 3-cycle RAM/multiplier pipeline flush.
//  Metric: m(L) = |acc_re| + |acc_im|, zero-extended to 28 bits.
//    The running best is replaced only if m(L) > best, so on ties the smallest lag wins.
//  DECIDE (1 cycle): done=1 and peak<=best.
//    If best>=THRESH: lock<=1 and delay<=best_lag.
//    Otherwise: lock<=0 and delay keeps its previous value.
//  Latency: done fires exactly (N+MAX_LAG) + MAX_LAG*(N+3) + 2 cycles after the clock edge that
//    registers the start rising edge; with the defaults this is 4418.
//  busy falls in the cycle after done.
//  A new start edge is accepted at the earliest in the cycle after done.
//  Inputs are don't-care outside CAPTURE; sign inversion or a constant phase rotation of fb does not
//    move the peak lag.
//  Reset mid-operation: returns to IDLE immediately; outputs cleared, partial results discarded.
//  Conjugate: conj(fb) = {fb_re, -fb_im}.
//    Negating -512 yields +512; the term is sign-extended to 11 bits before negation.
// TESTING
//  1 ref = random QPSK +/-2^18, fb = ref delayed 41 cycles -> done after 4418 cycles, lock=1, delay=41.
//  2 Lag boundaries: fb delayed 0 -> delay=0; fb delayed 63 -> delay=63; both with lock=1.
//  3 fb = -j*ref delayed 10, scaled by 1/4 -> delay=10, lock=1, peak > THRESH.
//  4 After test 1, repeat with fb=0 -> lock=0, delay stays 41, peak=0, done pulses once.
//  5 Start edge again 100 cycles into SEARCH -> ignored; single done at 4418.
//    Reset asserted at cycle 2000 -> all outputs 0, busy=0; a fresh start then completes normally.
//  6 ref periodic with period 16, fb = ref delayed 5 -> equal peaks at 5, 21, 37, 53 -> delay=5.

Source files
------------

// File: rtl/dpd_loop_delay_est.sv
// dpd_loop_delay_est: measures the tx->PA->feedback loop delay by cross-correlating a captured
// reference block against the feedback over a lag window and reporting the strongest lag.
module dpd_loop_delay_est #(
  parameter int          N       = 64,
  parameter int          MAX_LAG = 64,
  parameter logic [27:0] THRESH  = 28'd4096
) (
  input  logic               clk,
  input  logic               reset_b,
  input  logic               start,
  input  logic signed [19:0] ref_i,
  input  logic signed [19:0] ref_q,
  input  logic signed [19:0] fb_i,
  input  logic signed [19:0] fb_q,
  output logic               busy,
  output logic               done,
  output logic               lock,
  output logic [7:0]         delay,
  output logic [27:0]        peak
);
  localparam int D  = N + MAX_LAG;
  localparam int CW = $clog2(D + 3);
  localparam int AW = $clog2(D);
  localparam int RW = $clog2(N);
  localparam logic [CW-1:0] C_CAP_LAST = CW'(D - 1);
  localparam logic [CW-1:0] C_FLUSH    = CW'(N + 2);
  localparam logic [CW-1:0] C_N        = CW'(N);
  localparam logic [7:0]    LAG_LAST   = 8'(MAX_LAG - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, SEARCH, DECIDE} state_t;
  state_t state;
  logic start_d, v1, v2, m_vld, m_last;
  logic [CW-1:0] c;
  logic [7:0] lag, m_lag, best_lag;
  logic [19:0] ref_mem [N];
  logic [19:0] fb_mem [D];
  logic signed [9:0] r_re, r_im, f_re, f_im;
  logic signed [10:0] f_im_n;
  logic signed [20:0] p_re, p_im;
  logic signed [26:0] acc_re, acc_im;
  logic signed [27:0] x_re, x_im;
  logic [27:0] abs_re, abs_im, metric, best;
  logic [AW-1:0] fb_addr;
  logic unused;

  assign unused = ^{ref_i[9:0], ref_q[9:0], fb_i[9:0], fb_q[9:0]};

  always_comb begin
    f_im_n = -{f_im[9], f_im};
    x_re = 28'(acc_re);
    x_im = 28'(acc_im);
    abs_re = x_re[27] ? 28'(-x_re) : 28'(x_re);
    abs_im = x_im[27] ? 28'(-x_im) : 28'(x_im);
    fb_addr = c[AW-1:0] + AW'(lag);
  end

  // Buffers and the read/multiply/metric pipeline carry no reset; validity is tracked by v1/v2/m_vld.
  always_ff @(posedge clk) begin
    if (state == CAPTURE) begin
      fb_mem[c[AW-1:0]] <= {fb_i[19:10], fb_q[19:10]};
      if (c < C_N) ref_mem[c[RW-1:0]] <= {ref_i[19:10], ref_q[19:10]};
    end
    {r_re, r_im} <= ref_mem[c[RW-1:0]];
    {f_re, f_im} <= fb_mem[fb_addr];
    p_re <= 21'(r_re) * 21'(f_re) - 21'(r_im) * 21'(f_im_n);
    p_im <= 21'(r_re) * 21'(f_im_n) + 21'(r_im) * 21'(f_re);
    metric <= abs_re + abs_im;
    m_lag <= lag;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= IDLE;
      start_d <= 1'b0;
      c <= '0;
      lag <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      m_vld <= 1'b0;
      m_last <= 1'b0;
      acc_re <= '0;
      acc_im <= '0;
      best <= '0;
      best_lag <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      lock <= 1'b0;
      delay <= '0;
      peak <= '0;
    end else begin
      start_d <= start;
      done <= 1'b0;
      v1 <= state == SEARCH && c < C_N;
      v2 <= v1;
      m_vld <= state == SEARCH && c == C_FLUSH;
      m_last <= lag == LAG_LAST;
      if (state == SEARCH && c == C_FLUSH) begin
        acc_re <= '0;
        acc_im <= '0;
      end else if (v2) begin
        acc_re <= acc_re + 27'(p_re);
        acc_im <= acc_im + 27'(p_im);
      end
      // Strict compare keeps the smallest lag on ties.
      if (m_vld && metric > best) begin
        best <= metric;
        best_lag <= m_lag;
      end
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start && !start_d) begin
            state <= CAPTURE;
            busy <= 1'b1;
            c <= '0;
            lag <= '0;
            best <= '0;
            best_lag <= '0;
            acc_re <= '0;
            acc_im <= '0;
          end
        end
        CAPTURE: begin
          c <= c == C_CAP_LAST ? '0 : c + CW'(1);
          if (c == C_CAP_LAST) state <= SEARCH;
        end
        SEARCH: begin
          c <= c == C_FLUSH ? '0 : c + CW'(1);
          if (c == C_FLUSH) lag <= lag + 8'd1;
          if (m_vld && m_last) state <= DECIDE;
        end
        default: begin
          done <= 1'b1;
          peak <= best;
          lock <= best >= THRESH;
          if (best >= THRESH) delay <= best_lag;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dpd_loop_delay_est.sv
// tb_dpd_loop_delay_est: directed vectors for the loop delay estimator with hand-computed peaks.
module tb_dpd_loop_delay_est;
  logic clk = 1'b0, reset_b = 1'b0, start = 1'b0;
  logic signed [19:0] ref_i = '0, ref_q = '0, fb_i = '0, fb_q = '0;
  logic busy, done, lock;
  logic [7:0] delay;
  logic [27:0] peak;
  int cyc = 0, passed = 0, total = 0;
  logic signed [19:0] si [192], sq [192], ti [192], tq [192];
  bit [31:0] x = 32'h1234_5678;

  typedef struct {
    string  name;
    int     d;
    int     mode;
    int     inj;
    bit     lk;
    int     dl;
    longint pk;
  } vec_t;
  vec_t tab [7];

  dpd_loop_delay_est dut (
    .clk(clk), .reset_b(reset_b), .start(start),
    .ref_i(ref_i), .ref_q(ref_q), .fb_i(fb_i), .fb_q(fb_q),
    .busy(busy), .done(done), .lock(lock), .delay(delay), .peak(peak)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic signed [19:0] qpsk();
    x ^= x << 13;
    x ^= x >> 17;
    x ^= x << 5;
    return x[0] ? 20'sd262144 : -20'sd262144;
  endfunction

  // mode 0: fb = ref delayed d; 1: fb = -j*ref/4 delayed d; 2: fb = 0; 3: period-16 ref, fb delayed d
  task automatic drive(input int k, input int d, input int mode);
    int r, f;
    r = k + 64;
    f = k + 64 - d;
    ref_i = mode == 3 ? ti[r] : si[r];
    ref_q = mode == 3 ? tq[r] : sq[r];
    case (mode)
      0: begin fb_i = si[f]; fb_q = sq[f]; end
      1: begin fb_i = sq[f] >>> 2; fb_q = -(si[f] >>> 2); end
      2: begin fb_i = '0; fb_q = '0; end
      default: begin fb_i = ti[f]; fb_q = tq[f]; end
    endcase
  endtask

  task automatic run(input vec_t v);
    int e0, lat, nd;
    logic b_at_done;
    start = 1'b1;
    @(posedge clk); #1;
    e0 = cyc;
    start = 1'b0;
    chk({v.name, " busy_on_start"}, busy, 1);
    for (int k = 0; k < 128; k++) begin
      drive(k, v.d, v.mode);
      @(posedge clk); #1;
    end
    lat = -1;
    nd = 0;
    b_at_done = 1'b0;
    while (cyc - e0 < 4430) begin
      if (cyc - e0 == v.inj) start = 1'b1;
      if (cyc - e0 == v.inj + 3) start = 1'b0;
      if (done) begin
        nd++;
        if (lat < 0) begin
          lat = cyc - e0;
          b_at_done = busy;
        end
      end
      @(posedge clk); #1;
    end
    chk({v.name, " latency"}, lat, 4418);
    chk({v.name, " done_pulses"}, nd, 1);
    chk({v.name, " busy_at_done"}, b_at_done, 1);
    chk({v.name, " busy_after"}, busy, 0);
    chk({v.name, " lock"}, lock, v.lk);
    chk({v.name, " delay"}, delay, v.dl);
    chk({v.name, " peak"}, peak, v.pk);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " lock"}, lock, 0);
    chk({tag, " delay"}, delay, 0);
    chk({tag, " peak"}, peak, 0);
  endtask

  initial begin
    int e0;
    for (int i = 0; i < 192; i++) begin
      si[i] = qpsk();
      sq[i] = qpsk();
    end
    for (int i = 0; i < 192; i++) begin
      ti[i] = i < 16 ? qpsk() : ti[i % 16];
      tq[i] = i < 16 ? qpsk() : tq[i % 16];
    end
    // Peaks: 64 * (256^2 + 256^2) = 8388608 for an exact match; 1/4-scaled -j rotation gives 2097152.
    tab[0] = '{"lag41",     41, 0, -1, 1'b1, 41, 64'd8388608};
    tab[1] = '{"lag0",       0, 0, -1, 1'b1,  0, 64'd8388608};
    tab[2] = '{"lag63",     63, 0, -1, 1'b1, 63, 64'd8388608};
    tab[3] = '{"rot_scale", 10, 1, -1, 1'b1, 10, 64'd2097152};
    tab[4] = '{"lag41b",    41, 0, -1, 1'b1, 41, 64'd8388608};
    tab[5] = '{"fb_zero",   41, 2, -1, 1'b0, 41, 64'd0};
    tab[6] = '{"periodic",   5, 3, -1, 1'b1,  5, 64'd8388608};

    repeat (3) @(posedge clk);
    #1;
    chk_cleared("reset");
    reset_b = 1'b1;
    @(posedge clk); #1;

    foreach (tab[i]) run(tab[i]);

    run('{"restart_ignored", 41, 0, 228, 1'b1, 41, 64'd8388608});

    start = 1'b1;
    @(posedge clk); #1;
    e0 = cyc;
    start = 1'b0;
    for (int k = 0; k < 128; k++) begin
      drive(k, 41, 0);
      @(posedge clk); #1;
    end
    while (cyc - e0 < 2000) begin
      @(posedge clk); #1;
    end
    chk("mid_run busy", busy, 1);
    reset_b = 1'b0;
    #1;
    chk_cleared("mid_reset");
    @(posedge clk); #1;
    reset_b = 1'b1;
    @(posedge clk); #1;
    run('{"after_reset", 17, 0, -1, 1'b1, 17, 64'd8388608});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
